seq_sub: RTL



---
 rtl/seq_sub.sv | 112 +++++++++++
 1 files changed

// File: rtl/seq_sub.sv
// Digit-serial WIDTH-bit subtractor {bout,diff} = a - b - bin, DIGIT bits per cycle, LSB first.
// Optional macro SEQ_SUB_SAT_EN: unsigned saturation (diff forced to 0 when the final borrow is 1).
module seq_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       o_dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_sub;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_res_next;

  // Handshake: start is a request that is honoured only outside RUN; done is a
  // one-cycle valid strobe, and diff/bout stay valid until the next done.
  assign w_accept      = start && (r_state != S_RUN);
  assign w_last        = (r_cnt == CW'(N - 1));
  assign w_sub         = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
                       - {{DIGIT{1'b0}}, r_borrow};
  assign w_borrow_next = w_sub[DIGIT];

  // The minuend register doubles as the result shift register: each consumed
  // digit frees the top slot that receives the freshly computed difference.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_res_next = w_sub[DIGIT-1:0];
    end else begin : g_multi
      assign w_res_next = {w_sub[DIGIT-1:0], r_a[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a      <= w_res_next;
      r_b      <= r_b >> DIGIT;
      r_borrow <= w_borrow_next;
      if (!w_last) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
`ifdef SEQ_SUB_SAT_EN
        r_diff <= w_borrow_next ? '0 : w_res_next;
`else
        r_diff <= w_res_next;
`endif
        r_bout <= w_borrow_next;
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign diff        = r_diff;
  assign bout        = r_bout;
  assign o_dbg_state = r_state;

endmodule
